// File: rtl/npu_layer_controller_pkg.sv
// Shared definitions for the NPU layer controller and its register file:
// FSM state encodings, error codes and activation-type codes.
package npu_layer_controller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CHECK      = 4'd1,
    ST_LOAD       = 4'd2,
    ST_COMPUTE    = 4'd3,
    ST_ACTIVATE   = 4'd4,
    ST_WRITE_BACK = 4'd5,
    ST_NEXT_LAYER = 4'd6,
    ST_DONE       = 4'd7,
    ST_ERROR      = 4'd8
  } npu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_BAD_SIZE   = 2'd1,
    ERR_BAD_LAYERS = 2'd2,
    ERR_TIMEOUT    = 2'd3
  } npu_err_e;

  typedef enum logic [1:0] {
    ACT_NONE    = 2'd0,
    ACT_RELU    = 2'd1,
    ACT_SIGMOID = 2'd2,
    ACT_TANH    = 2'd3
  } npu_act_e;

  // States during which the controller reports busy.
  function automatic logic state_is_busy(input npu_state_e s);
    return s inside {ST_CHECK, ST_LOAD, ST_COMPUTE, ST_ACTIVATE,
                     ST_WRITE_BACK, ST_NEXT_LAYER};
  endfunction

endpackage

// File: rtl/npu_layer_controller_sat_counter.sv
// Up-counter with synchronous clear (priority over inc) and optional
// saturation at all-ones.
module npu_sat_counter #(
  parameter int unsigned WIDTH    = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count register: clear wins, then increment unless pinned at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && !(SATURATE && (count == '1))) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/npu_layer_controller.sv
// Multi-layer NPU controller: sequences LOAD / COMPUTE / ACTIVATE /
// WRITE_BACK for up to MAX_LAYERS layers per start, swaps ping-pong buffers
// between layers, and reports errors, timeouts and busy-cycle count.
module npu_layer_controller
  import npu_layer_controller_pkg::*;
#(
  parameter  int unsigned MATRIX_SIZE = 8,
  parameter  int unsigned MAX_LAYERS  = 4,
  parameter  int unsigned TIMEOUT_W   = 16,
  parameter  int unsigned LOAD_CYCLES = 2,
  parameter  int unsigned WB_CYCLES   = 2,
  localparam int unsigned LW          = $clog2(MAX_LAYERS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    soft_reset,
  input  logic [LW-1:0]           num_layers,
  input  logic [2*MAX_LAYERS-1:0] layer_act,
  input  logic [7:0]              matrix_size,
  input  logic [TIMEOUT_W-1:0]    timeout_limit,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [3:0]              current_state,
  output logic [LW-1:0]           layer_idx,
  output logic                    mmu_start,
  output logic                    mmu_clear,
  input  logic                    mmu_done,
  output logic [1:0]              act_type,
  input  logic                    act_valid,
  output logic                    input_buf_rd_en,
  output logic                    weight_buf_rd_en,
  output logic                    output_buf_wr_en,
  output logic                    swap_buf,
  output logic                    interrupt,
  output logic [31:0]             busy_cycles
);

  localparam int unsigned PHASE_MAX = (LOAD_CYCLES > WB_CYCLES) ? LOAD_CYCLES : WB_CYCLES;
  localparam int unsigned PW        = $clog2(PHASE_MAX + 1);
  localparam logic [7:0]    MAX_SIZE = 8'(MATRIX_SIZE);
  localparam logic [LW-1:0] MAX_L    = LW'(MAX_LAYERS);
  localparam logic [PW-1:0] LOAD_LAST = PW'(LOAD_CYCLES - 1);
  localparam logic [PW-1:0] WB_LAST   = PW'(WB_CYCLES - 1);

  npu_state_e state, state_d;
  logic [1:0]              err_d;
  logic [LW-1:0]           layer_idx_d;
  logic [PW-1:0]           phase, phase_d;

  logic [7:0]              cfg_size;
  logic [LW-1:0]           cfg_layers;
  logic [2*MAX_LAYERS-1:0] cfg_act;
  logic [TIMEOUT_W-1:0]    cfg_timeout;

  logic [TIMEOUT_W-1:0]    wait_cnt;
  logic                    wait_clr;
  logic                    wait_expired;
  logic                    busy_clr;

  // Activation code for a given layer index out of the packed per-layer field.
  function automatic logic [1:0] act_of(input logic [2*MAX_LAYERS-1:0] acts,
                                        input logic [LW-1:0]           idx);
    logic [1:0] a;
    a = ACT_NONE;
    for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
      if (idx == LW'(i)) a = acts[2*i +: 2];
    end
    return a;
  endfunction

  // Counter controls. The wait counter restarts on entry to COMPUTE and
  // again on the COMPUTE->ACTIVATE hand-off, so each wait gets a full limit.
  always_comb begin
    wait_clr     = soft_reset
                 || !(state inside {ST_COMPUTE, ST_ACTIVATE})
                 || ((state == ST_COMPUTE) && mmu_done);
    wait_expired = (cfg_timeout != '0) && (wait_cnt == cfg_timeout - TIMEOUT_W'(1));
    busy_clr     = soft_reset || ((state == ST_IDLE) && start);
  end

  npu_sat_counter #(
    .WIDTH    (TIMEOUT_W),
    .SATURATE (1'b1)
  ) u_wait_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (wait_clr),
    .inc   (1'b1),
    .count (wait_cnt)
  );

  npu_sat_counter #(
    .WIDTH    (32),
    .SATURATE (1'b1)
  ) u_busy_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (busy_clr),
    .inc   (busy),
    .count (busy_cycles)
  );

  // Next-state, next error code, next layer index and phase counter.
  always_comb begin
    state_d     = state;
    err_d       = err_code;
    layer_idx_d = layer_idx;
    phase_d     = phase;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_CHECK;
          layer_idx_d = '0;
        end
      end
      ST_CHECK: begin
        if ((cfg_size == 8'd0) || (cfg_size > MAX_SIZE)) begin
          state_d = ST_ERROR;
          err_d   = ERR_BAD_SIZE;
        end else if ((cfg_layers == '0) || (cfg_layers > MAX_L)) begin
          state_d = ST_ERROR;
          err_d   = ERR_BAD_LAYERS;
        end else begin
          state_d     = ST_LOAD;
          layer_idx_d = '0;
          phase_d     = '0;
        end
      end
      ST_LOAD: begin
        if (phase == LOAD_LAST) begin
          state_d = ST_COMPUTE;
          phase_d = '0;
        end else begin
          phase_d = phase + PW'(1);
        end
      end
      ST_COMPUTE: begin
        if (mmu_done) begin
          state_d = ST_ACTIVATE;
        end else if (wait_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_ACTIVATE: begin
        if (act_valid) begin
          state_d = ST_WRITE_BACK;
          phase_d = '0;
        end else if (wait_expired) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      ST_WRITE_BACK: begin
        if (phase == WB_LAST) begin
          phase_d = '0;
          state_d = (layer_idx == cfg_layers - LW'(1)) ? ST_DONE : ST_NEXT_LAYER;
        end else begin
          phase_d = phase + PW'(1);
        end
      end
      ST_NEXT_LAYER: begin
        state_d     = ST_LOAD;
        layer_idx_d = layer_idx + LW'(1);
        phase_d     = '0;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, latched configuration and registered outputs. Outputs are
  // decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      phase            <= '0;
      cfg_size         <= '0;
      cfg_layers       <= '0;
      cfg_act          <= '0;
      cfg_timeout      <= '0;
      err_code         <= ERR_NONE;
      layer_idx        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      interrupt        <= 1'b0;
      mmu_start        <= 1'b0;
      mmu_clear        <= 1'b0;
      act_type         <= '0;
      input_buf_rd_en  <= 1'b0;
      weight_buf_rd_en <= 1'b0;
      output_buf_wr_en <= 1'b0;
      swap_buf         <= 1'b0;
    end else if (soft_reset) begin
      state            <= ST_IDLE;
      phase            <= '0;
      cfg_size         <= '0;
      cfg_layers       <= '0;
      cfg_act          <= '0;
      cfg_timeout      <= '0;
      err_code         <= ERR_NONE;
      layer_idx        <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      error            <= 1'b0;
      interrupt        <= 1'b0;
      mmu_start        <= 1'b0;
      mmu_clear        <= 1'b0;
      act_type         <= '0;
      input_buf_rd_en  <= 1'b0;
      weight_buf_rd_en <= 1'b0;
      output_buf_wr_en <= 1'b0;
      swap_buf         <= 1'b0;
    end else begin
      state     <= state_d;
      phase     <= phase_d;
      err_code  <= err_d;
      layer_idx <= layer_idx_d;
      if ((state == ST_IDLE) && start) begin
        cfg_size    <= matrix_size;
        cfg_layers  <= num_layers;
        cfg_act     <= layer_act;
        cfg_timeout <= timeout_limit;
      end
      busy             <= state_is_busy(state_d);
      done             <= (state_d == ST_DONE);
      error            <= (state_d == ST_ERROR);
      interrupt        <= (state_d == ST_DONE) ||
                          ((state_d == ST_ERROR) && (state != ST_ERROR));
      mmu_start        <= (state_d == ST_COMPUTE) && (state != ST_COMPUTE);
      mmu_clear        <= (state_d == ST_LOAD);
      input_buf_rd_en  <= state_d inside {ST_LOAD, ST_COMPUTE};
      weight_buf_rd_en <= state_d inside {ST_LOAD, ST_COMPUTE};
      output_buf_wr_en <= (state_d == ST_WRITE_BACK);
      swap_buf         <= (state_d == ST_NEXT_LAYER);
      if ((state_d == ST_LOAD) && (state != ST_LOAD)) begin
        act_type <= act_of(cfg_act, layer_idx_d);
      end
    end
  end

  assign current_state = state;

endmodule

// File: tb/tb_npu_layer_controller.sv
// Randomized self-checking bench for npu_layer_controller. Expected event
// cycles are derived from the per-layer latency arithmetic of the block.
module tb_npu_layer_controller;

  localparam int MAX_LAYERS = 4;
  localparam int LW         = 3;
  localparam int LOAD_C     = 2;
  localparam int WB_C       = 2;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        soft_reset;
  logic [2:0]  num_layers;
  logic [7:0]  layer_act;
  logic [7:0]  matrix_size;
  logic [15:0] timeout_limit;
  logic        busy, done, error;
  logic [1:0]  err_code;
  logic [3:0]  current_state;
  logic [2:0]  layer_idx;
  logic        mmu_start, mmu_clear, mmu_done;
  logic [1:0]  act_type;
  logic        act_valid;
  logic        input_buf_rd_en, weight_buf_rd_en, output_buf_wr_en;
  logic        swap_buf, interrupt;
  logic [31:0] busy_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int cw[4];
  int aw[4];

  npu_layer_controller #(
    .MATRIX_SIZE (8),
    .MAX_LAYERS  (4),
    .TIMEOUT_W   (16),
    .LOAD_CYCLES (2),
    .WB_CYCLES   (2)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .soft_reset       (soft_reset),
    .num_layers       (num_layers),
    .layer_act        (layer_act),
    .matrix_size      (matrix_size),
    .timeout_limit    (timeout_limit),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .err_code         (err_code),
    .current_state    (current_state),
    .layer_idx        (layer_idx),
    .mmu_start        (mmu_start),
    .mmu_clear        (mmu_clear),
    .mmu_done         (mmu_done),
    .act_type         (act_type),
    .act_valid        (act_valid),
    .input_buf_rd_en  (input_buf_rd_en),
    .weight_buf_rd_en (weight_buf_rd_en),
    .output_buf_wr_en (output_buf_wr_en),
    .swap_buf         (swap_buf),
    .interrupt        (interrupt),
    .busy_cycles      (busy_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {busy, done, error, err_code, current_state, layer_idx, mmu_start,
            mmu_clear, act_type, input_buf_rd_en, weight_buf_rd_en,
            output_buf_wr_en, swap_buf, interrupt, busy_cycles};
  endfunction

  // One run: model the expected timeline, drive it, compare events.
  task automatic run(input string name, input int nl, input int sz, input int tmo,
                     input logic [7:0] acts, input int abort_layer);
    int exp_ms[$]; int exp_sw[$]; int got_ms[$]; int got_sw[$];
    int exp_kind, exp_end, exp_busy, exp_wr, abort_cyc, t, s, as, wb, last;
    int cyc, budget, n_ms, cur, sched_done, sched_act;
    int busy_cnt, irq_cnt, wr_cnt, end_kind, end_cyc, end_bc, end_irq, late;
    bit got_end;

    // reference timeline (cycle 1 = CHECK)
    abort_cyc = 0; exp_wr = 0; exp_kind = 0; exp_end = 0; exp_busy = 0;
    if (sz < 1 || sz > 8) begin
      exp_kind = 1; exp_end = 2; exp_busy = 1;
    end else if (nl < 1 || nl > MAX_LAYERS) begin
      exp_kind = 2; exp_end = 2; exp_busy = 1;
    end else begin
      t = 2;
      for (int i = 0; i < nl; i++) begin
        s = t + LOAD_C;
        exp_ms.push_back(s);
        if (tmo != 0 && cw[i] > tmo) begin
          exp_kind = 3; exp_end = s + tmo; exp_busy = exp_end - 1; break;
        end
        as = s + cw[i];
        if (tmo != 0 && aw[i] > tmo) begin
          exp_kind = 3; exp_end = as + tmo; exp_busy = exp_end - 1; break;
        end
        wb   = as + aw[i];
        last = wb + WB_C - 1;
        exp_wr += WB_C;
        if (i == abort_layer) begin
          exp_kind = 4; abort_cyc = wb; exp_end = wb; break;
        end
        if (i == nl - 1) begin
          exp_kind = 0; exp_end = last + 1; exp_busy = last;
        end else begin
          exp_sw.push_back(last + 1);
          t = last + 2;
        end
      end
    end

    @(negedge clk);
    num_layers    = 3'(nl);
    matrix_size   = 8'(sz);
    timeout_limit = 16'(tmo);
    layer_act     = acts;
    start         = 1'b1;
    @(negedge clk);
    start = 1'b0;

    cyc = 1; budget = exp_end + 20; n_ms = 0; cur = 0;
    sched_done = -1; sched_act = -1; busy_cnt = 0; irq_cnt = 0; wr_cnt = 0;
    end_kind = -1; end_cyc = -1; end_bc = 0; end_irq = 0; got_end = 0;
    while (!got_end && cyc <= budget) begin
      if (busy) busy_cnt++;
      if (interrupt) irq_cnt++;
      if (output_buf_wr_en) wr_cnt++;
      if (swap_buf) got_sw.push_back(cyc);
      if (mmu_start) begin
        got_ms.push_back(cyc);
        if (n_ms < nl && n_ms < MAX_LAYERS) begin
          check_eq({name, ":act_type"}, act_type, acts[2*n_ms +: 2]);
          check_eq({name, ":layer_idx"}, layer_idx, n_ms);
          cur = n_ms;
          sched_done = cyc + cw[n_ms] - 1;
        end
        n_ms++;
      end
      if (exp_kind == 4 && cyc == abort_cyc) begin
        check_eq({name, ":wr_en_at_abort"}, output_buf_wr_en, 1);
        soft_reset = 1'b1;
        got_end = 1; end_cyc = cyc;
      end else if (done || error) begin
        got_end = 1; end_cyc = cyc;
        end_kind = done ? 0 : int'(err_code);
        end_bc = busy_cycles; end_irq = interrupt;
      end
      mmu_done = (cyc == sched_done);
      if (mmu_done) sched_act = cyc + aw[cur];
      act_valid = (cyc == sched_act);
      @(negedge clk);
      mmu_done = 1'b0; act_valid = 1'b0; soft_reset = 1'b0;
      cyc++;
    end

    check_eq({name, ":end_seen"}, got_end, 1);
    if (!got_end) begin
      soft_reset = 1'b1;
      @(negedge clk);
      soft_reset = 1'b0;
    end else if (exp_kind == 4) begin
      check_eq({name, ":abort_cycle"}, end_cyc, exp_end);
      check_eq({name, ":abort_outputs"}, all_out(), 0);
      late = 0;
      for (int k = 0; k < 6; k++) begin
        if (done || interrupt || busy) late++;
        @(negedge clk);
      end
      check_eq({name, ":abort_quiet"}, late, 0);
    end else begin
      check_eq({name, ":end_kind"}, end_kind, exp_kind);
      check_eq({name, ":end_cycle"}, end_cyc, exp_end);
      check_eq({name, ":busy_cycles"}, end_bc, exp_busy);
      check_eq({name, ":busy_count"}, busy_cnt, exp_busy);
      check_eq({name, ":irq_at_end"}, end_irq, 1);
      check_eq({name, ":irq_count"}, irq_cnt, 1);
      check_eq({name, ":mmu_start_n"}, got_ms.size(), exp_ms.size());
      for (int i = 0; i < got_ms.size() && i < exp_ms.size(); i++)
        check_eq({name, ":mmu_start_cyc"}, got_ms[i], exp_ms[i]);
      check_eq({name, ":swap_n"}, got_sw.size(), exp_sw.size());
      for (int i = 0; i < got_sw.size() && i < exp_sw.size(); i++)
        check_eq({name, ":swap_cyc"}, got_sw[i], exp_sw[i]);
      if (exp_kind == 0) begin
        check_eq({name, ":wr_count"}, wr_cnt, exp_wr);
        check_eq({name, ":post_done"}, {done, busy, interrupt}, 3'b000);
        check_eq({name, ":post_busy_cycles"}, busy_cycles, exp_busy);
        check_eq({name, ":post_layer_idx"}, layer_idx, nl - 1);
      end else begin
        check_eq({name, ":err_held"}, {error, busy, interrupt}, 3'b100);
        check_eq({name, ":err_code_held"}, err_code, exp_kind);
        start = 1'b1;
        repeat (3) @(negedge clk);
        check_eq({name, ":start_ignored"}, {error, busy, err_code}, {2'b10, 2'(exp_kind)});
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        start = 1'b0;
        check_eq({name, ":soft_reset_outputs"}, all_out(), 0);
        @(negedge clk);
        check_eq({name, ":stays_idle"}, all_out(), 0);
      end
    end
  endtask

  initial begin
    int errs;
    rst_n = 1'b0; start = 1'b0; soft_reset = 1'b0; num_layers = '0;
    layer_act = '0; matrix_size = '0; timeout_limit = '0;
    mmu_done = 1'b0; act_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", all_out(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("after_reset_idle", all_out(), 0);

    // three layers, ReLU / none / sigmoid, mmu_done 5 cycles after mmu_start
    cw = '{6, 6, 6, 6}; aw = '{3, 3, 3, 3};
    run("three_layers", 3, 8, 0, 8'b00_10_00_01, -1);
    run("bad_size", 1, 0, 0, 8'h00, -1);
    run("bad_layers", 5, 4, 0, 8'h00, -1);
    run("size_priority", 0, 9, 0, 8'h00, -1);
    cw = '{1000, 1, 1, 1};
    run("compute_timeout", 1, 8, 10, 8'h03, -1);
    cw = '{10, 1, 1, 1}; aw = '{2, 2, 2, 2};
    run("done_on_timeout_edge", 1, 8, 10, 8'h02, -1);
    cw = '{2, 2, 2, 2}; aw = '{2, 9, 2, 2};
    run("activate_timeout", 2, 8, 8, 8'hE4, -1);
    cw = '{3, 4, 5, 2}; aw = '{2, 2, 2, 2};
    run("abort_layer2_wb", 3, 8, 0, 8'h1B, 1);
    cw = '{4, 1, 1, 1}; aw = '{3, 1, 1, 1};
    run("single_layer", 1, 1, 0, 8'h01, -1);
    cw = '{1, 1, 1, 1}; aw = '{1, 1, 1, 1};
    run("max_layers_min_waits", 4, 8, 1, 8'h9C, -1);

    // timeout disabled: no error after 1000 cycles of waiting
    @(negedge clk);
    num_layers = 3'd1; matrix_size = 8'd4; timeout_limit = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    errs = 0;
    for (int k = 1; k < 1003; k++) begin
      if (error) errs++;
      @(negedge clk);
    end
    check_eq("no_timeout:error", errs, 0);
    check_eq("no_timeout:busy", busy, 1);
    check_eq("no_timeout:busy_cycles", busy_cycles, 1002);
    soft_reset = 1'b1;
    @(negedge clk);
    soft_reset = 1'b0;
    check_eq("no_timeout:soft_reset", all_out(), 0);

    for (int r = 0; r < 24; r++) begin
      int nl, sz, tmo, sel;
      sel = int'($urandom_range(0, 9));
      nl  = (sel == 0) ? 0 : (sel == 1) ? 5 : int'($urandom_range(1, 4));
      sel = int'($urandom_range(0, 9));
      sz  = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(9, 255)) : int'($urandom_range(1, 8));
      tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(6, 16));
      for (int i = 0; i < 4; i++) begin
        cw[i] = int'($urandom_range(1, 12));
        aw[i] = int'($urandom_range(1, 12));
      end
      run("random", nl, sz, tmo, 8'($urandom), -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
